// File: rtl/decoder3to8_pulse.sv
// Registered 3-to-8 decoder: each accepted code drives one bit of y high for HOLD cycles,
// with a one-entry pending buffer so consecutive codes play back-to-back.
module decoder3to8_pulse #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       active,
  output logic       done
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          HOLD1    = (HOLD == 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    pend_code;
  logic          pend_valid;
  logic          accept;
  logic          last;

  assign in_ready = en && !pend_valid;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_code  <= '0;
      pend_valid <= 1'b0;
      y          <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
    end else if (!en) begin
      // abort: drop the running pulse and any pending code, no done
      state      <= IDLE;
      cnt        <= '0;
      pend_valid <= 1'b0;
      y          <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state  <= ACTIVE;
            y      <= 8'b1 << code;
            active <= 1'b1;
            cnt    <= CNT_INIT;
            done   <= HOLD1;
          end
        end
        ACTIVE: begin
          if (!last) begin
            cnt  <= cnt - CNT_ONE;
            done <= (cnt == CNT_ONE);
            if (accept) begin
              pend_valid <= 1'b1;
              pend_code  <= code;
            end
          end else if (pend_valid) begin
            y          <= 8'b1 << pend_code;
            cnt        <= CNT_INIT;
            done       <= HOLD1;
            pend_valid <= 1'b0;
          end else if (accept) begin
            y    <= 8'b1 << code;
            cnt  <= CNT_INIT;
            done <= HOLD1;
          end else begin
            state  <= IDLE;
            y      <= '0;
            active <= 1'b0;
            done   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder3to8_pulse.sv
// Directed bench for decoder3to8_pulse: HOLD=4 instance for most sequences, HOLD=1 instance
// for the single-cycle back-to-back case.
module tb_decoder3to8_pulse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, in_valid, in_ready;
  logic [2:0] code;
  logic [7:0] y;
  logic       active, done;
  logic       en1, in_valid1, in_ready1;
  logic [2:0] code1;
  logic [7:0] y1;
  logic       active1, done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decoder3to8_pulse #(.HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .code(code), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .active(active), .done(done)
  );

  decoder3to8_pulse #(.HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .code(code1), .in_valid(in_valid1),
    .in_ready(in_ready1), .y(y1), .active(active1), .done(done1)
  );

  typedef struct {
    logic [2:0] code;
    logic [7:0] exp_y;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after the accept edge; checks a full 4-cycle pulse then idle.
  task automatic pulse4(input string name, input logic [7:0] exp_y);
    for (int c = 0; c < 4; c++) begin
      chk({name, "_y"}, 32'(y), 32'(exp_y));
      chk({name, "_active"}, 32'(active), 1);
      chk({name, "_done"}, 32'(done), (c == 3) ? 1 : 0);
      step();
    end
    chk({name, "_idle_y"}, 32'(y), 0);
    chk({name, "_idle_active"}, 32'(active), 0);
    chk({name, "_idle_done"}, 32'(done), 0);
  endtask

  initial begin
    vec_t sweep[8];
    logic [7:0] ey;
    for (int i = 0; i < 8; i++) begin
      sweep[i].code  = 3'(i);
      sweep[i].exp_y = 8'b1 << i;
    end

    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; code = '0;
    en1 = 1'b1; in_valid1 = 1'b0; code1 = '0;
    #12;
    chk("rst_y", 32'(y), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(in_ready), 1);

    // basic pulse, code 5
    code = 3'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    pulse4("basic5", 8'h20);

    // table sweep of all codes
    for (int i = 0; i < 8; i++) begin
      code = sweep[i].code; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      pulse4($sformatf("sweep%0d", i), sweep[i].exp_y);
    end

    // back-to-back through the pending buffer: 2, 6, 1
    code = 3'd2; in_valid = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      ey = (i < 4) ? 8'h04 : (i < 8) ? 8'h40 : 8'h02;
      chk($sformatf("b2b_y%0d", i), 32'(y), 32'(ey));
      chk($sformatf("b2b_done%0d", i), 32'(done), (i % 4 == 3) ? 1 : 0);
      chk($sformatf("b2b_ready%0d", i), 32'(in_ready),
          (i == 0 || i == 4 || i >= 8) ? 1 : 0);
      if (i == 0) code = 3'd6;
      if (i == 1) code = 3'd1;
      if (i == 5) in_valid = 1'b0;
      step();
    end
    chk("b2b_end_y", 32'(y), 0);
    chk("b2b_end_active", 32'(active), 0);

    // HOLD=1: consecutive single-cycle pulses
    code1 = 3'd0; in_valid1 = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("h1_y%0d", i), 32'(y1), 32'(8'b1 << i));
      chk($sformatf("h1_done%0d", i), 32'(done1), 1);
      chk($sformatf("h1_ready%0d", i), 32'(in_ready1), 1);
      if (i < 3) code1 = 3'(i + 1);
      else in_valid1 = 1'b0;
      step();
    end
    chk("h1_end_y", 32'(y1), 0);
    chk("h1_end_done", 32'(done1), 0);

    // en dropped in cycle 2 of a pulse with a pending code
    code = 3'd3; in_valid = 1'b1;
    step();
    chk("abort_c1_y", 32'(y), 32'(8'h08));
    code = 3'd7;
    step();
    chk("abort_pend_ready", 32'(in_ready), 0);
    in_valid = 1'b0; en = 1'b0;
    chk("abort_ready_en0", 32'(in_ready), 0);
    step();
    chk("abort_y", 32'(y), 0);
    chk("abort_active", 32'(active), 0);
    chk("abort_done", 32'(done), 0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_nopend_y%0d", i), 32'(y), 0);
      chk($sformatf("abort_nodone%0d", i), 32'(done), 0);
      step();
    end
    code = 3'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    pulse4("after_abort", 8'h10);

    // en low with in_valid high: no accept
    en = 1'b0; code = 3'd2; in_valid = 1'b1;
    step();
    chk("en0_valid_y", 32'(y), 0);
    in_valid = 1'b0; en = 1'b1;
    step();
    chk("en0_valid_y2", 32'(y), 0);

    // asynchronous reset mid-pulse
    code = 3'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("arst_pre_y", 32'(y), 32'(8'h40));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 0);
    chk("arst_active", 32'(active), 0);
    chk("arst_done", 32'(done), 0);
    #2 rst_n = 1'b1;
    step();
    chk("arst_rel_y", 32'(y), 0);
    code = 3'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    pulse4("after_rst", 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
